// File: rtl/lcg_pkg.sv
// Shared types and constants for the LCG sequence generator.
// Holds the default width, the product width and the FSM state type.
package lcg_pkg;

  localparam int LCG_WIDTH = 32;
  localparam int PROD_W    = 2 * LCG_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    MOD,
    OUT,
    ERR
  } state_t;

endpackage

// File: rtl/lcg_modred.sv
// Sequential restoring reducer: r = p mod m, one product bit per cycle.
// The last iteration's remainder is presented combinationally with done.
module lcg_modred
  import lcg_pkg::*;
#(
  parameter int WIDTH = LCG_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH:0]   p,
  input  logic [WIDTH-1:0]   m,
  output logic               done,
  output logic [WIDTH-1:0]   r
);

  localparam int PW = 2 * WIDTH + 1;
  localparam int CW = $clog2(PW + 1);

  logic [PW-1:0]    p_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH:0]   s;
  logic [WIDTH:0]   r_nxt;
  logic [CW-1:0]    cnt;
  logic             active;
  logic             ge;

  // one shift-subtract step: bring in the next product MSB
  always_comb begin
    s     = {r_q[WIDTH-1:0], p_q[PW-1]};
    ge    = r_q[WIDTH] | (s >= {1'b0, m});
    r_nxt = ge ? (s - {1'b0, m}) : s;
  end

  assign done = active && (cnt == CW'(1));
  assign r    = r_nxt[WIDTH-1:0];

  // load on start, then iterate once per product bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      r_q    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      p_q    <= p;
      r_q    <= '0;
      cnt    <= CW'(PW);
      active <= 1'b1;
    end else if (active) begin
      p_q    <= {p_q[PW-2:0], 1'b0};
      r_q    <= r_nxt;
      cnt    <= cnt - CW'(1);
      active <= (cnt != CW'(1));
    end
  end

endmodule

// File: rtl/lcg_gen.sv
// Forward LCG generator: v(n+1) = (v(n)*a + c) mod m.
// Owns the FSM, the output handshake and the coefficient latches.
module lcg_gen
  import lcg_pkg::*;
#(
  parameter int WIDTH = LCG_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] MODULUS,
  input  logic [WIDTH-1:0] MULTIPLIER,
  input  logic [WIDTH-1:0] INCREMENT,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             busy,
  output logic             error
);

  localparam int PW = 2 * WIDTH + 1;
  localparam int XW = PW - WIDTH;

  state_t           st;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] c_q;
  logic [PW-1:0]    prod;
  logic             start;
  logic             done;
  logic [WIDTH-1:0] r;

  // untruncated product; seed may exceed m so no pre-reduction
  always_comb begin
    prod = {{XW{1'b0}}, cur} * {{XW{1'b0}}, a_q}
         + {{XW{1'b0}}, c_q};
  end

  assign start = (st == MUL);

  lcg_modred #(
    .WIDTH(WIDTH)
  ) u_red (
    .clk   (CLK),
    .rst_n (RST_N),
    .start (start),
    .p     (prod),
    .m     (m_q),
    .done  (done),
    .r     (r)
  );

  // control FSM; a load in any state restarts from the new seed
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st        <= IDLE;
      cur       <= '0;
      m_q       <= '0;
      a_q       <= '0;
      c_q       <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else if (seed_load) begin
      cur       <= seed;
      m_q       <= MODULUS;
      a_q       <= MULTIPLIER;
      c_q       <= INCREMENT;
      out_valid <= 1'b0;
      if (MODULUS == '0) begin
        st    <= ERR;
        busy  <= 1'b0;
        error <= 1'b1;
      end else begin
        st    <= MUL;
        busy  <= 1'b1;
        error <= 1'b0;
      end
    end else begin
      unique case (st)
        IDLE: begin
        end
        MUL: begin
          st <= MOD;
        end
        MOD: begin
          if (done) begin
            out_value <= r;
            cur       <= r;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            st        <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b1;
            st        <= MUL;
          end
        end
        ERR: begin
          error     <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcg_gen.sv
// Self-checking bench for lcg_gen.
// Table-driven sequences with a scoreboard queue plus corner cases.
module tb_lcg_gen;
  import lcg_pkg::*;

  logic        CLK;
  logic        RST_N;
  logic [31:0] MODULUS;
  logic [31:0] MULTIPLIER;
  logic [31:0] INCREMENT;
  logic        seed_load;
  logic [31:0] seed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_value;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] seed;
    logic [31:0] m;
    logic [31:0] a;
    logic [31:0] c;
    int          n;
    bit          chk0;
    logic [31:0] exp0;
  } vec_t;

  vec_t vecs[5];

  lcg_gen dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .MODULUS    (MODULUS),
    .MULTIPLIER (MULTIPLIER),
    .INCREMENT  (INCREMENT),
    .seed_load  (seed_load),
    .seed       (seed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_value  (out_value),
    .busy       (busy),
    .error      (error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] lcg_next(
    input logic [31:0] v,
    input logic [31:0] a,
    input logic [31:0] c,
    input logic [31:0] m
  );
    logic [PROD_W-1:0] p;
    logic [PROD_W-1:0] q;
    p = {33'b0, v} * {33'b0, a} + {33'b0, c};
    q = p % {33'b0, m};
    return q[31:0];
  endfunction

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // drive a load at the current negedge; return at the next negedge
  task automatic do_load(input logic [31:0] s, input logic [31:0] m,
                         input logic [31:0] a, input logic [31:0] c);
    seed       = s;
    MODULUS    = m;
    MULTIPLIER = a;
    INCREMENT  = c;
    seed_load  = 1'b1;
    @(negedge CLK);
    seed_load  = 1'b0;
    MODULUS    = 32'h5A5A_5A5A;
    MULTIPLIER = 32'h1234_5678;
    INCREMENT  = 32'h0BAD_F00D;
    seed       = 32'hFFFF_0000;
  endtask

  // count edges until out_valid; busy must be high while waiting
  task automatic wait_valid(input string nm, output int lat);
    bit busy_bad;
    lat = 0;
    busy_bad = 1'b0;
    while (!out_valid && lat < 200) begin
      if (!busy) busy_bad = 1'b1;
      @(negedge CLK);
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'd66);
    check({nm, "_busy_wait"}, 64'(busy_bad), 64'd0);
    check({nm, "_busy_out"}, 64'(busy), 64'd0);
  endtask

  task automatic run_vec(input int idx);
    logic [31:0] v;
    int lat;
    out_ready = 1'b1;
    do_load(vecs[idx].seed, vecs[idx].m, vecs[idx].a, vecs[idx].c);
    v = vecs[idx].seed;
    for (int k = 0; k < vecs[idx].n; k++) begin
      v = lcg_next(v, vecs[idx].a, vecs[idx].c, vecs[idx].m);
      exp_q.push_back(v);
    end
    for (int k = 0; k < vecs[idx].n; k++) begin
      wait_valid($sformatf("vec%0d_%0d", idx, k), lat);
      if (k == 0 && vecs[idx].chk0)
        check($sformatf("vec%0d_v0", idx), 64'(out_value),
              64'(vecs[idx].exp0));
      check($sformatf("vec%0d_val%0d", idx, k), 64'(out_value),
            64'(exp_q.pop_front()));
      @(negedge CLK);
    end
  endtask

  initial begin
    int lat;
    bit stable;
    bit seen;

    vecs[0] = '{32'd96, 32'd993441, 32'd4001, 32'd60211, 3, 1'b1,
                32'd444307};
    vecs[1] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFF, 2, 1'b1, 32'd0};
    vecs[2] = '{32'd12345, 32'd1, 32'd7, 32'd9, 3, 1'b1, 32'd0};
    vecs[3] = '{32'd5000000, 32'd993441, 32'd4001, 32'd60211, 2,
                1'b0, 32'd0};
    vecs[4] = '{32'hDEAD_BEEF, 32'hFFFF_FFFB, 32'h41C6_4E6D,
                32'd12345, 2, 1'b0, 32'd0};

    RST_N      = 1'b0;
    seed_load  = 1'b0;
    seed       = '0;
    MODULUS    = '0;
    MULTIPLIER = '0;
    INCREMENT  = '0;
    out_ready  = 1'b0;

    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_value", 64'(out_value), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    check("exp_table_v1", 64'(lcg_next(32'd444307, 32'd4001,
          32'd60211, 32'd993441)), 64'd466569);

    for (int i = 0; i < 5; i++) run_vec(i);

    // stall: value held while out_ready low
    out_ready = 1'b0;
    do_load(32'd96, 32'd993441, 32'd4001, 32'd60211);
    wait_valid("stall_first", lat);
    stable = 1'b1;
    repeat (10) begin
      if (!out_valid || out_value !== 32'd444307) stable = 1'b0;
      @(negedge CLK);
    end
    check("stall_stable", 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check("stall_drop", 64'(out_valid), 64'd0);
    wait_valid("stall_second", lat);
    check("stall_v1", 64'(out_value), 64'd466569);

    // load and handshake on one edge: load wins
    out_ready = 1'b1;
    do_load(32'd97, 32'd993441, 32'd4001, 32'd60211);
    check("ld_hs_drop", 64'(out_valid), 64'd0);
    wait_valid("ld_hs", lat);
    check("ld_hs_val", 64'(out_value), 64'd448308);

    // zero modulus
    do_load(32'd96, 32'd0, 32'd4001, 32'd60211);
    check("err_set", 64'(error), 64'd1);
    check("err_valid", 64'(out_valid), 64'd0);
    check("err_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      if (out_valid || !error) seen = 1'b1;
      @(negedge CLK);
    end
    check("err_hold", 64'(seen), 64'd0);
    do_load(32'd96, 32'd993441, 32'd4001, 32'd60211);
    check("err_clear", 64'(error), 64'd0);
    wait_valid("err_recover", lat);
    check("err_recover_val", 64'(out_value), 64'd444307);
    @(negedge CLK);

    // abort mid-reduction
    do_load(32'd96, 32'd993441, 32'd4001, 32'd60211);
    repeat (29) @(negedge CLK);
    do_load(32'd97, 32'd993441, 32'd4001, 32'd60211);
    wait_valid("abort", lat);
    check("abort_val", 64'(out_value), 64'd448308);
    @(negedge CLK);

    // asynchronous reset while holding an output
    out_ready = 1'b0;
    do_load(32'd96, 32'd993441, 32'd4001, 32'd60211);
    wait_valid("arst_pre", lat);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_error", 64'(error), 64'd0);
    check("arst_value", 64'(out_value), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      if (out_valid || busy) seen = 1'b1;
      @(negedge CLK);
    end
    check("arst_idle", 64'(seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
